// File: rtl/lru_victim_pick.sv
// Per-set LRU rank store (rank 0 = MRU) with a valid/ready victim offer path.
// Optional rank-permutation self-check and repair: define LRU_PERM_CHECK_EN.
module lru_victim_pick #(
  parameter int WIDTH   = 3,
  parameter int SET_LOG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hit_en,
  input  logic [SET_LOG-1:0] hit_set,
  input  logic [WIDTH-1:0]   hit_way,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [SET_LOG-1:0] miss_set,
  output logic               victim_valid,
  input  logic               victim_ready,
  output logic [SET_LOG-1:0] victim_set,
  output logic [WIDTH-1:0]   victim_way,
  output logic               lru_err
);
  localparam int WAYS = 1 << WIDTH;
  localparam int SETS = 1 << SET_LOG;
  localparam logic [WIDTH-1:0] LRU = WIDTH'(WAYS - 1);

  typedef logic [WAYS-1:0][WIDTH-1:0] rank_t;
  typedef enum logic [1:0] {IDLE, LOOKUP, OFFER} state_t;

  function automatic rank_t init_rank();
    rank_t o;
    for (int k = 0; k < WAYS; k++) o[k] = WIDTH'(k);
    return o;
  endfunction

  // Move way w to rank 0; everything that was more recent than w ages by one.
  function automatic rank_t promote(rank_t r, logic [WIDTH-1:0] w);
    rank_t o;
    o = r;
    for (int k = 0; k < WAYS; k++)
      if (r[k] < r[w]) o[k] = r[k] + 1'b1;
    o[w] = '0;
    return o;
  endfunction

  state_t               r_state;
  logic                 r_victim_valid;
  logic [SET_LOG-1:0]   r_victim_set;
  logic [WIDTH-1:0]     r_victim_way;
  rank_t [SETS-1:0]     r_rank;
  rank_t [SETS-1:0]     w_hit_rank;
  rank_t [SETS-1:0]     w_rank_nxt;
  rank_t                w_lk;
  logic [WIDTH-1:0]     w_pick;
  logic                 w_alloc;
  logic                 w_withdraw;

  assign w_alloc    = (r_state == OFFER) && victim_ready;
  assign w_withdraw = (r_state == OFFER) && !victim_ready && hit_en &&
                      (hit_set == r_victim_set) && (hit_way == r_victim_way);
  // Gated by rst_n so nothing can be accepted while reset is held.
  assign miss_ready   = rst_n && (r_state == IDLE);
  assign victim_valid = r_victim_valid;
  assign victim_set   = r_victim_set;
  assign victim_way   = r_victim_way;

  // Lookup sees the set after this cycle's hit, so a same-cycle hit steers the pick.
  assign w_lk = w_hit_rank[r_victim_set];

  always_comb begin
    w_pick = '0;
    for (int k = WAYS - 1; k >= 0; k--)
      if (w_lk[k] == LRU) w_pick = WIDTH'(k);
  end

`ifdef LRU_PERM_CHECK_EN
  logic [WAYS-1:0] w_seen;
  logic            w_bad;
  logic            r_err;

  always_comb begin
    w_seen = '0;
    for (int k = 0; k < WAYS; k++) w_seen[w_lk[k]] = 1'b1;
  end

  assign w_bad   = (r_state == LOOKUP) && !(&w_seen);
  assign lru_err = r_err;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     r_err <= 1'b0;
    else if (w_bad) r_err <= 1'b1;
`else
  assign lru_err = 1'b0;
`endif

  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic w_hs, w_as;
    assign w_hs = hit_en && (hit_set == SET_LOG'(s));
    assign w_as = w_alloc && (r_victim_set == SET_LOG'(s));
    // Hit applies before allocate when both land on this set in one cycle.
    assign w_hit_rank[s] = w_hs ? promote(r_rank[s], hit_way) : r_rank[s];
`ifdef LRU_PERM_CHECK_EN
    assign w_rank_nxt[s] = (w_bad && (r_victim_set == SET_LOG'(s))) ? init_rank() :
                           w_as ? promote(w_hit_rank[s], r_victim_way) : w_hit_rank[s];
`else
    assign w_rank_nxt[s] = w_as ? promote(w_hit_rank[s], r_victim_way) : w_hit_rank[s];
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rank <= {SETS{init_rank()}};
    else        r_rank <= w_rank_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_victim_valid <= 1'b0;
      r_victim_set   <= '0;
      r_victim_way   <= '0;
    end else begin
      case (r_state)
        IDLE: if (miss_valid) begin
          r_victim_set <= miss_set;
          r_state      <= LOOKUP;
        end
        LOOKUP: begin
`ifdef LRU_PERM_CHECK_EN
          r_victim_way <= w_bad ? LRU : w_pick;
`else
          r_victim_way <= w_pick;
`endif
          r_victim_valid <= 1'b1;
          r_state        <= OFFER;
        end
        OFFER: if (victim_ready) begin
          r_victim_valid <= 1'b0;
          r_state        <= IDLE;
        end else if (w_withdraw) begin
          r_victim_valid <= 1'b0;
          r_state        <= LOOKUP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lru_victim_pick.sv
// Directed bench for lru_victim_pick: queue-based scoreboard of offered victims plus a rank model.
module tb_lru_victim_pick;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       hit_en = 1'b0, miss_valid = 1'b0, victim_ready = 1'b0;
  logic [3:0] hit_set = '0, miss_set = '0;
  logic [2:0] hit_way = '0;
  logic       miss_ready, victim_valid, lru_err;
  logic [3:0] victim_set;
  logic [2:0] victim_way;

  typedef struct packed {logic [3:0] set; logic [2:0] way;} exp_t;
  exp_t       sb[$];
  logic [2:0] m [16][8];
  int         n_pass = 0, n_tot = 0;

  lru_victim_pick #(.WIDTH(3), .SET_LOG(4)) dut (
    .clk(clk), .rst_n(rst_n), .hit_en(hit_en), .hit_set(hit_set), .hit_way(hit_way),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set),
    .victim_valid(victim_valid), .victim_ready(victim_ready), .victim_set(victim_set),
    .victim_way(victim_way), .lru_err(lru_err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    for (int s = 0; s < 16; s++)
      for (int k = 0; k < 8; k++) m[s][k] = 3'(k);
  endtask

  task automatic m_promote(input int s, input logic [2:0] w);
    logic [2:0] r;
    r = m[s][w];
    for (int k = 0; k < 8; k++)
      if (m[s][k] < r) m[s][k] = m[s][k] + 3'd1;
    m[s][w] = 3'd0;
  endtask

  function automatic int m_victim(input int s);
    for (int k = 0; k < 8; k++)
      if (m[s][k] == 3'd7) return k;
    return 0;
  endfunction

  task automatic hit(input logic [3:0] s, input logic [2:0] w);
    @(negedge clk);
    hit_en = 1'b1; hit_set = s; hit_way = w;
    m_promote(s, w);
    @(negedge clk);
    hit_en = 1'b0;
  endtask

  // Full request/offer/handshake; exp_way < 0 takes the expected victim from the model.
  task automatic miss(input logic [3:0] s, input int exp_way, input int hold,
                      input bit lk_hit, input logic [2:0] lk_way);
    exp_t e;
    int   w;
    @(negedge clk);
    miss_valid = 1'b1; miss_set = s;
    chk("miss_ready_idle", miss_ready, 1);
    if (lk_hit) m_promote(s, lk_way);
    w = (exp_way < 0) ? m_victim(s) : exp_way;
    sb.push_back('{set: s, way: 3'(w)});
    @(negedge clk);
    miss_valid = 1'b0;
    if (lk_hit) begin hit_en = 1'b1; hit_set = s; hit_way = lk_way; end
    chk("lat1_valid", victim_valid, 0);
    chk("lookup_ready", miss_ready, 0);
    @(negedge clk);
    hit_en = 1'b0;
    chk("lat2_valid", victim_valid, 1);
    e = sb.pop_front();
    chk("victim_set", victim_set, e.set);
    chk("victim_way", victim_way, e.way);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", victim_valid, 1);
      chk("hold_way", victim_way, e.way);
    end
    victim_ready = 1'b1;
    m_promote(s, e.way);
    @(negedge clk);
    victim_ready = 1'b0;
    chk("victim_drop", victim_valid, 0);
  endtask

  initial begin
    exp_t e;
    int d1[8] = '{6, 5, 4, 3, 2, 1, 0, 7};
    int d4[8] = '{6, 5, 4, 3, 1, 0, 2, 7};
    m_reset();

    #12;
    chk("rst_miss_ready", miss_ready, 0);
    chk("rst_victim_valid", victim_valid, 0);
    chk("rst_victim_set", victim_set, 0);
    chk("rst_victim_way", victim_way, 0);
    chk("rst_lru_err", lru_err, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("idle_ready", miss_ready, 1);

    // fresh set: LRU is way 7; drain reveals ranks {1..7,0}
    miss(4'd5, 7, 0, 1'b0, 3'd0);
    foreach (d1[i]) miss(4'd5, d1[i], 0, 1'b0, 3'd0);

    for (int w = 0; w < 8; w++) hit(4'd3, 3'(w));
    miss(4'd3, 0, 2, 1'b0, 3'd0);

    // hit during LOOKUP on the way that would have been picked
    miss(4'd10, 6, 1, 1'b1, 3'd7);

    // offer withdrawal, with an unrelated-set hit during the offer
    @(negedge clk); miss_valid = 1'b1; miss_set = 4'd2;
    sb.push_back('{set: 4'd2, way: 3'd7});
    @(negedge clk); miss_valid = 1'b0;
    @(negedge clk);
    chk("t3_valid", victim_valid, 1);
    e = sb.pop_front();
    chk("t3_way", victim_way, e.way);
    hit_en = 1'b1; hit_set = 4'd9; hit_way = 3'd7; m_promote(9, 3'd7);
    @(negedge clk);
    chk("t3_other_hit_valid", victim_valid, 1);
    chk("t3_other_hit_way", victim_way, e.way);
    hit_set = 4'd2; hit_way = 3'd7; m_promote(2, 3'd7);
    sb.push_back('{set: 4'd2, way: 3'(m_victim(2))});
    @(negedge clk); hit_en = 1'b0;
    chk("t3_withdraw", victim_valid, 0);
    @(negedge clk);
    chk("t3_reoffer_valid", victim_valid, 1);
    e = sb.pop_front();
    chk("t3_reoffer_way", victim_way, e.way);
    chk("t3_reoffer_const", victim_way, 6);
    victim_ready = 1'b1; m_promote(2, e.way);
    @(negedge clk); victim_ready = 1'b0;
    chk("t3_drop", victim_valid, 0);

    miss(4'd9, 6, 0, 1'b0, 3'd0);
    miss(4'd2, -1, 0, 1'b0, 3'd0);

    // handshake and different-way hit in the same cycle
    @(negedge clk); miss_valid = 1'b1; miss_set = 4'd4;
    sb.push_back('{set: 4'd4, way: 3'd7});
    @(negedge clk); miss_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid", victim_valid, 1);
    e = sb.pop_front();
    chk("t4_way", victim_way, e.way);
    victim_ready = 1'b1; hit_en = 1'b1; hit_set = 4'd4; hit_way = 3'd2;
    m_promote(4, 3'd2); m_promote(4, 3'd7);
    @(negedge clk); victim_ready = 1'b0; hit_en = 1'b0;
    chk("t4_drop", victim_valid, 0);
    foreach (d4[i]) miss(4'd4, d4[i], 0, 1'b0, 3'd0);

    // reset while offering
    hit(4'd6, 3'd7);
    @(negedge clk); miss_valid = 1'b1; miss_set = 4'd6;
    sb.push_back('{set: 4'd6, way: 3'(m_victim(6))});
    @(negedge clk); miss_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", victim_valid, 1);
    e = sb.pop_front();
    chk("t5_way", victim_way, e.way);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", victim_valid, 0);
    chk("t5_rst_ready", miss_ready, 0);
    chk("t5_rst_way", victim_way, 0);
    chk("t5_rst_set", victim_set, 0);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    miss(4'd6, 7, 0, 1'b0, 3'd0);
    miss(4'd5, 7, 0, 1'b0, 3'd0);
    miss(4'd3, 7, 0, 1'b0, 3'd0);
    chk("lru_err_clear", lru_err, 0);

`ifdef LRU_PERM_CHECK_EN
    @(negedge clk); miss_valid = 1'b1; miss_set = 4'd1;
    @(negedge clk); miss_valid = 1'b0;
    force dut.r_rank = '0;
    @(negedge clk);
    release dut.r_rank;
    chk("t6_err", lru_err, 1);
    chk("t6_valid", victim_valid, 1);
    chk("t6_way", victim_way, 7);
    victim_ready = 1'b1;
    @(negedge clk); victim_ready = 1'b0;
    miss(4'd1, 7, 0, 1'b0, 3'd0);
    miss(4'd1, 6, 0, 1'b0, 3'd0);
    chk("t6_err_sticky", lru_err, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
